// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, ALU function encodings and the
// packed control word passed from the decoder to the datapath.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_CMP  = 4'h5;
  localparam logic [3:0] OP_IMM0 = 4'h6;
  localparam logic [3:0] OP_IMM1 = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JC0  = 4'hB;
  localparam logic [3:0] OP_JC1  = 4'hC;
  localparam logic [3:0] OP_JC2  = 4'hD;
  localparam logic [3:0] OP_BR0  = 4'hE;
  localparam logic [3:0] OP_BR1  = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       compare;
    logic       mem_read;
    logic       mem_write;
    logic       alu0;
    logic       alu1;
    logic [1:0] alu_func;
    logic       reg_load;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Pure combinational opcode-to-control-word lookup.
module control_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OP_AND: begin
        ctrl_o.alu0 = 1'b1; ctrl_o.alu1 = 1'b1; ctrl_o.reg_load = 1'b1;
        ctrl_o.alu_func = ALU_AND;
      end
      OP_OR: begin
        ctrl_o.alu0 = 1'b1; ctrl_o.alu1 = 1'b1; ctrl_o.reg_load = 1'b1;
        ctrl_o.alu_func = ALU_OR;
      end
      OP_ADD: begin
        ctrl_o.alu0 = 1'b1; ctrl_o.alu1 = 1'b1; ctrl_o.reg_load = 1'b1;
        ctrl_o.alu_func = ALU_ADD;
      end
      OP_SUB: begin
        ctrl_o.alu0 = 1'b1; ctrl_o.alu1 = 1'b1; ctrl_o.reg_load = 1'b1;
        ctrl_o.alu_func = ALU_SUB;
      end
      OP_CMP: begin
        ctrl_o.alu0 = 1'b1; ctrl_o.alu1 = 1'b1; ctrl_o.compare = 1'b1;
      end
      OP_IMM0, OP_IMM1: begin
        ctrl_o.alu0 = 1'b1; ctrl_o.reg_load = 1'b1;
      end
      OP_LD: begin
        ctrl_o.alu0 = 1'b1; ctrl_o.mem_read = 1'b1; ctrl_o.reg_load = 1'b1;
      end
      // Store address comes straight from the register path, not the ALU.
      OP_ST: begin
        ctrl_o.mem_write = 1'b1; ctrl_o.reg_load = 1'b1;
      end
      OP_JMP: begin
        ctrl_o.jump = 1'b1; ctrl_o.alu0 = 1'b1;
      end
      OP_JC0, OP_JC1, OP_JC2: begin
        ctrl_o.jump = 1'b1; ctrl_o.compare = 1'b1; ctrl_o.alu0 = 1'b1;
      end
      OP_BR0, OP_BR1: begin
        ctrl_o.branch = 1'b1; ctrl_o.alu0 = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main instruction decoder: wraps control_decode with reset gating and an
// optional output register stage (REG_OUT=1) for pipelined integration.
module control_unit
  import cpu_pkg::*;
#(
  parameter bit REG_OUT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  output logic       branch,
  output logic       jump,
  output logic       compare,
  output logic       memRead,
  output logic       memWrite,
  output logic       alu0,
  output logic       alu1,
  output logic [1:0] aluFunc,
  output logic       regLoad
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_out;

  control_decode u_decode (
    .opcode_i (opcode),
    .ctrl_o   (ctrl_d)
  );

  generate
    if (REG_OUT) begin : g_reg
      ctrl_t ctrl_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ctrl_q <= '0;
        else        ctrl_q <= ctrl_d;
      end

      assign ctrl_out = ctrl_q;
    end else begin : g_comb
      // clk has no role in the combinational build.
      logic unused_clk;
      assign unused_clk = clk;
      assign ctrl_out   = rst_n ? ctrl_d : '0;
    end
  endgenerate

  assign branch   = ctrl_out.branch;
  assign jump     = ctrl_out.jump;
  assign compare  = ctrl_out.compare;
  assign memRead  = ctrl_out.mem_read;
  assign memWrite = ctrl_out.mem_write;
  assign alu0     = ctrl_out.alu0;
  assign alu1     = ctrl_out.alu1;
  assign aluFunc  = ctrl_out.alu_func;
  assign regLoad  = ctrl_out.reg_load;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit, exercising a combinational and a
// registered instance side by side from the same opcode stream.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = 4'h3;

  logic       br_c, jp_c, cmp_c, mr_c, mw_c, a0_c, a1_c, rl_c;
  logic [1:0] af_c;
  logic       br_r, jp_r, cmp_r, mr_r, mw_r, a0_r, a1_r, rl_r;
  logic [1:0] af_r;

  control_unit #(.REG_OUT(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .branch(br_c), .jump(jp_c), .compare(cmp_c), .memRead(mr_c), .memWrite(mw_c),
    .alu0(a0_c), .alu1(a1_c), .aluFunc(af_c), .regLoad(rl_c)
  );

  control_unit #(.REG_OUT(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .branch(br_r), .jump(jp_r), .compare(cmp_r), .memRead(mr_r), .memWrite(mw_r),
    .alu0(a0_r), .alu1(a1_r), .aluFunc(af_r), .regLoad(rl_r)
  );

  always #5 clk = ~clk;

  // Word layout: {branch, jump, compare, memRead, memWrite, alu0, alu1, aluFunc[1:0], regLoad}
  logic [9:0] act_c, act_r;
  assign act_c = {br_c, jp_c, cmp_c, mr_c, mw_c, a0_c, a1_c, af_c, rl_c};
  assign act_r = {br_r, jp_r, cmp_r, mr_r, mw_r, a0_r, a1_r, af_r, rl_r};

  logic [9:0] exp_tab [16];
  initial begin
    exp_tab[0]  = 10'b00000_0_0_00_0;
    exp_tab[1]  = 10'b00000_1_1_10_1;
    exp_tab[2]  = 10'b00000_1_1_11_1;
    exp_tab[3]  = 10'b00000_1_1_00_1;
    exp_tab[4]  = 10'b00000_1_1_01_1;
    exp_tab[5]  = 10'b00100_1_1_00_0;
    exp_tab[6]  = 10'b00000_1_0_00_1;
    exp_tab[7]  = 10'b00000_1_0_00_1;
    exp_tab[8]  = 10'b00010_1_0_00_1;
    exp_tab[9]  = 10'b00001_0_0_00_1;
    exp_tab[10] = 10'b01000_1_0_00_0;
    exp_tab[11] = 10'b01100_1_0_00_0;
    exp_tab[12] = 10'b01100_1_0_00_0;
    exp_tab[13] = 10'b01100_1_0_00_0;
    exp_tab[14] = 10'b10000_1_0_00_0;
    exp_tab[15] = 10'b10000_1_0_00_0;
  end

  typedef struct {
    logic [3:0] op;
    logic [9:0] exp;
    int         due;
  } item_t;

  item_t q_c[$];
  item_t q_r[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  task automatic chk_inv(input string name, input logic [3:0] op, input logic [9:0] act);
    checks++;
    if ((act[6] & act[5]) !== 1'b0 || (act[9] & act[8]) !== 1'b0 ||
        (!(op == 4'h1 || op == 4'h2 || op == 4'h4) && act[2:1] !== 2'b00)) begin
      errors++;
      $display("FAIL %s: op %h outputs %b break an invariant", name, op, act);
    end
  endtask

  // Monitor: compare each output sample against whatever entries are due now.
  always @(negedge clk) begin
    item_t it;
    while (q_c.size() > 0 && q_c[0].due == cyc) begin
      it = q_c.pop_front();
      chk($sformatf("comb op=%h", it.op), act_c, it.exp);
      chk_inv("inv_comb", it.op, act_c);
    end
    while (q_r.size() > 0 && q_r[0].due == cyc) begin
      it = q_r.pop_front();
      chk($sformatf("reg  op=%h", it.op), act_r, it.exp);
      chk_inv("inv_reg", it.op, act_r);
    end
  end

  task automatic drive(input logic [3:0] op);
    item_t it;
    @(posedge clk);
    #1;
    opcode = op;
    it.op  = op;
    it.exp = exp_tab[op];
    it.due = cyc;
    q_c.push_back(it);
    it.due = cyc + 1;
    q_r.push_back(it);
  endtask

  initial begin
    // Reset state with a live opcode on the input.
    #7;
    chk("reset comb", act_c, 10'd0);
    chk("reset reg", act_r, 10'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency pair, then full sweep.
    drive(4'h2);
    drive(4'h9);
    for (int i = 0; i < 16; i++) drive(i[3:0]);

    // Asynchronous reset with LOAD held on the input.
    drive(4'h8);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst comb", act_c, 10'd0);
    chk("async rst reg", act_r, 10'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("release comb", act_c, exp_tab[8]);
    chk("release reg holds 0", act_r, 10'd0);
    @(posedge clk);
    #1;
    chk("release reg after edge", act_r, exp_tab[8]);

    // Random opcodes with invariant checks on every sample.
    for (int i = 0; i < 1000; i++) drive(4'($urandom_range(0, 15)));

    begin
      int budget = 10;
      while ((q_c.size() > 0 || q_r.size() > 0) && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      checks++;
      if (q_c.size() > 0 || q_r.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d comb and %0d reg entries left, expected 0", q_c.size(), q_r.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
